// File: rtl/cic_interp_if.sv
// Ready/valid sample bus for cic_interp: input stream in, interpolated stream out.
// The DUT takes the slave modport; the stream source/sink side takes master.
interface cic_interp_if #(
   parameter int WIDTH = 8
);
   logic signed [WIDTH-1:0] i_in_data;
   logic                    i_in_valid;
   logic                    o_in_ready;
   logic signed [WIDTH-1:0] o_out_data;
   logic                    o_out_valid;
   logic                    i_out_ready;

   modport slave (
      input  i_in_data, i_in_valid, i_out_ready,
      output o_in_ready, o_out_data, o_out_valid
   );

   modport master (
      output i_in_data, i_in_valid, i_out_ready,
      input  o_in_ready, o_out_data, o_out_valid
   );
endinterface

// File: rtl/cic_interp.sv
// Signed CIC interpolator: N combs, zero-stuff upsample by RATE, N integrators, scale + saturate.
// Define CIC_INTERP_ROUND_EN for round-half-up scaling; otherwise the scaler truncates (floor).
module cic_interp #(
   parameter int WIDTH      = 8,
   parameter int NUM_STAGES = 3,
   parameter int RATE       = 4
) (
   input  logic        i_clock,
   input  logic        i_reset,
   cic_interp_if.slave bus
);
   localparam int LOG2R = $clog2(RATE);
   localparam int ACC_W = WIDTH + NUM_STAGES * LOG2R;
   localparam int SHIFT = (NUM_STAGES - 1) * LOG2R;
   localparam logic [LOG2R-1:0] LAST_PHASE = LOG2R'(RATE - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef CIC_INTERP_ROUND_EN
   localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'((64'd1 << SHIFT) >> 1);
`else
   localparam logic signed [ACC_W-1:0] ROUND_K = '0;
`endif

   logic signed [ACC_W-1:0] comb_q  [NUM_STAGES];
   logic signed [ACC_W-1:0] comb_d  [NUM_STAGES];
   logic signed [ACC_W-1:0] integ_q [NUM_STAGES];
   logic signed [ACC_W-1:0] integ_d [NUM_STAGES];
   logic [LOG2R-1:0]        phase_q, phase_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0] out_data_q, out_data_d;
   logic                    slot_free, phase_zero, fire;
   logic signed [ACC_W-1:0] stage_val, integ_sum, scaled;
   logic signed [WIDTH-1:0] sat_val;

   // A stalled output freezes every register, including the comb delays and phase.
   assign slot_free       = !out_valid_q || bus.i_out_ready;
   assign phase_zero      = (phase_q == '0);
   assign fire            = slot_free && (!phase_zero || bus.i_in_valid);
   assign bus.o_in_ready  = slot_free && phase_zero;
   assign bus.o_out_valid = out_valid_q;
   assign bus.o_out_data  = out_data_q;

   always_comb begin
      stage_val = {{(ACC_W - WIDTH){bus.i_in_data[WIDTH-1]}}, bus.i_in_data};
      for (int k = 0; k < NUM_STAGES; k++) begin
         comb_d[k] = (fire && phase_zero) ? stage_val : comb_q[k];
         stage_val = stage_val - comb_q[k];
      end
      if (!phase_zero) stage_val = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         stage_val  = integ_q[k] + stage_val;
         integ_d[k] = fire ? stage_val : integ_q[k];
      end
      integ_sum = stage_val;
   end

   // Integrator headroom covers the rounding constant, so only the WIDTH clamp is needed.
   always_comb begin
      scaled = (integ_sum + ROUND_K) >>> SHIFT;
      if (scaled > SAT_MAX) begin
         sat_val = SAT_MAX[WIDTH-1:0];
      end else if (scaled < SAT_MIN) begin
         sat_val = SAT_MIN[WIDTH-1:0];
      end else begin
         sat_val = scaled[WIDTH-1:0];
      end
   end

   always_comb begin
      phase_d     = phase_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (fire) begin
         phase_d     = (phase_q == LAST_PHASE) ? '0 : phase_q + LOG2R'(1);
         out_valid_d = 1'b1;
         out_data_d  = sat_val;
      end else if (bus.i_out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            comb_q[k]  <= '0;
            integ_q[k] <= '0;
         end
         phase_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         comb_q      <= comb_d;
         integ_q     <= integ_d;
         phase_q     <= phase_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule
